// File: rtl/dmem_responder_if.sv
// Data request/grant/rvalid bus between the core's data port (master) and memory (slave).
// Handshake: a request is valid while data_req_i is high, and its fields stay stable until
// the cycle where data_gnt_o is high. data_rvalid_o pulses once, one cycle after each grant.
interface dmem_responder_if;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [6:0]  data_wdata_intg_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic [6:0]  data_rdata_intg_o;
  logic        data_err_o;

  modport master (
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i, data_wdata_intg_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_rdata_intg_o, data_err_o
  );

  modport slave (
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i, data_wdata_intg_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_rdata_intg_o, data_err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Memory-side responder for the core data port: grant after a programmable stall,
// byte-enable writes, synchronous reads, and a registered response one cycle after grant.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0010_0000,
  parameter int unsigned STALL_CYCLES = 0
) (
  input logic             clk_i,
  input logic             rst_i,
  dmem_responder_if.slave bus
);

  localparam int unsigned IW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [3:0]    cnt;
  logic          gnt;
  logic [31:0]   off;
  logic          hit;
  logic [IW-1:0] index;
  logic [31:0]   rdata_next;
  logic [6:0]    intg_next;

  logic          rvalid_q;
  logic          err_q;
  logic [31:0]   rdata_q;
  logic [6:0]    intg_q;

  logic          unused_bits;

  assign gnt = bus.data_req_i && (cnt == 4'(STALL_CYCLES));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= 4'd0;
    end else if (bus.data_req_i && !gnt) begin
      cnt <= cnt + 4'd1;
    end else begin
      cnt <= 4'd0;
    end
  end

  // Address decode, evaluated only meaningfully in the grant cycle.
  always_comb begin
    off   = bus.data_addr_i - BASE_ADDR;
    hit   = (bus.data_addr_i >= BASE_ADDR) && ({1'b0, off} < SPAN) &&
            (bus.data_addr_i[1:0] == 2'b00);
    index = off[IW+1:2];
  end

  assign unused_bits = ^{off[31:IW+2], off[1:0], bus.data_wdata_intg_i};

  // Memory is deliberately outside reset: writes granted during reset still land.
  always_ff @(posedge clk_i) begin
    if (gnt && bus.data_we_i && hit) begin
      for (int n = 0; n < 4; n++) begin
        if (bus.data_be_i[n]) begin
          mem[index][8*n +: 8] <= bus.data_wdata_i[8*n +: 8];
        end
      end
    end
  end

  always_comb begin
    rdata_next = 32'h0;
    if (hit && !bus.data_we_i) begin
      rdata_next = mem[index];
    end
    intg_next = 7'b0000000;
    for (int n = 0; n < 4; n++) begin
      intg_next[n] = ~^rdata_next[8*n +: 8];
    end
  end

  // Response fields hold between pulses; only rvalid is cleared every cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
      intg_q   <= 7'b0001111;
    end else begin
      rvalid_q <= gnt;
      if (gnt) begin
        err_q   <= !hit;
        rdata_q <= rdata_next;
        intg_q  <= intg_next;
      end
    end
  end

  assign bus.data_gnt_o        = gnt;
  assign bus.data_rvalid_o     = rvalid_q;
  assign bus.data_err_o        = err_q;
  assign bus.data_rdata_o      = rdata_q;
  assign bus.data_rdata_intg_o = intg_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with no stall, one with three stall cycles,
// compared against a word-array reference model.
module tb_dmem_responder;

  localparam logic [31:0] BASE  = 32'h0010_0000;
  localparam int unsigned DEPTH = 1024;

  logic clk;
  logic rst;

  dmem_responder_if if0 ();
  dmem_responder_if if3 ();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .STALL_CYCLES(0)) u0 (
    .clk_i(clk), .rst_i(rst), .bus(if0.slave)
  );
  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .STALL_CYCLES(3)) u3 (
    .clk_i(clk), .rst_i(rst), .bus(if3.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard and reference model
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem0 [int];
  logic [31:0] mem3 [int];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
  endtask

  function automatic logic is_hit(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE);
    return (off >= 0) && (off < 4 * DEPTH) && (a % 4 == 0);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [6:0] exp_intg(input logic [31:0] d);
    logic [6:0] r;
    r = 7'b0;
    for (int i = 0; i < 4; i++) r[i] = ($countones(d[8*i +: 8]) % 2) == 0;
    return r;
  endfunction

  function automatic logic [31:0] model_rd(input bit sel, input logic [31:0] a);
    int w;
    w = word_of(a);
    if (sel) return mem3.exists(w) ? mem3[w] : 32'hxxxx_xxxx;
    return mem0.exists(w) ? mem0[w] : 32'hxxxx_xxxx;
  endfunction

  task automatic model_wr(input bit sel, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] d);
    logic [31:0] cur;
    cur = model_rd(sel, a);
    for (int i = 0; i < 4; i++) if (be[i]) cur[8*i +: 8] = d[8*i +: 8];
    if (sel) mem3[word_of(a)] = cur;
    else     mem0[word_of(a)] = cur;
  endtask

  // driver tasks
  task automatic drive(input bit sel, input logic req, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (sel) begin
      if3.data_req_i = req; if3.data_we_i = we; if3.data_be_i = be;
      if3.data_addr_i = addr; if3.data_wdata_i = wdata; if3.data_wdata_intg_i = 7'($urandom);
    end else begin
      if0.data_req_i = req; if0.data_we_i = we; if0.data_be_i = be;
      if0.data_addr_i = addr; if0.data_wdata_i = wdata; if0.data_wdata_intg_i = 7'($urandom);
    end
  endtask

  function automatic logic get_gnt(input bit sel);
    return sel ? if3.data_gnt_o : if0.data_gnt_o;
  endfunction

  task automatic run_txn(input bit sel, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
    int waited;
    bit got;
    logic e_hit;
    logic [31:0] e_rdata;
    @(negedge clk);
    drive(sel, 1'b1, we, be, addr, wdata);
    waited = 0;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (get_gnt(sel)) begin
        got = 1;
        break;
      end
      @(negedge clk);
      waited++;
    end
    check("gnt_seen", 32'(got), 32'd1);
    if (got) check("gnt_wait", waited, sel ? 32'd3 : 32'd0);
    e_hit   = is_hit(addr);
    e_rdata = (e_hit && !we) ? model_rd(sel, addr) : 32'h0;
    exp_q.push_back(e_rdata);
    if (e_hit && we) model_wr(sel, addr, be, wdata);
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    e_rdata = exp_q.pop_front();
    if (sel) begin
      check("rvalid", 32'(if3.data_rvalid_o), 32'd1);
      check("err", 32'(if3.data_err_o), 32'(!e_hit));
      check("rdata", if3.data_rdata_o, e_rdata);
      check("intg", 32'(if3.data_rdata_intg_o), 32'(exp_intg(e_rdata)));
    end else begin
      check("rvalid", 32'(if0.data_rvalid_o), 32'd1);
      check("err", 32'(if0.data_err_o), 32'(!e_hit));
      check("rdata", if0.data_rdata_o, e_rdata);
      check("intg", 32'(if0.data_rdata_intg_o), 32'(exp_intg(e_rdata)));
    end
  endtask

  logic [31:0] a;
  logic [31:0] d;

  initial begin
    drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
    drive(1, 0, 0, 4'h0, 32'h0, 32'h0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_rvalid", 32'(if0.data_rvalid_o), 32'd0);
    check("rst_err", 32'(if0.data_err_o), 32'd0);
    check("rst_rdata", if0.data_rdata_o, 32'h0);
    check("rst_intg", 32'(if0.data_rdata_intg_o), 32'h0F);
    check("rst_gnt_idle", 32'(if0.data_gnt_o), 32'd0);
    check("rst3_rvalid", 32'(if3.data_rvalid_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // basic write/read
    run_txn(0, 1, 4'hF, 32'h0010_0004, 32'hDEAD_BEEF);
    run_txn(0, 0, 4'hF, 32'h0010_0004, 32'h0);

    // byte enables and zero-enable write
    run_txn(0, 1, 4'hF, 32'h0010_0008, 32'h1122_3344);
    run_txn(0, 1, 4'b0101, 32'h0010_0008, 32'hAABB_CCDD);
    run_txn(0, 0, 4'hF, 32'h0010_0008, 32'h0);
    check("be_merge_model", model_rd(0, 32'h0010_0008), 32'h11BB_33DD);
    run_txn(0, 1, 4'b0000, 32'h0010_0008, 32'hFFFF_FFFF);
    run_txn(0, 0, 4'hF, 32'h0010_0008, 32'h0);

    // misses leave memory unchanged
    run_txn(0, 1, 4'hF, 32'h0010_0000, 32'h5A5A_0001);
    run_txn(0, 1, 4'hF, 32'h0000_0000, 32'hFFFF_FFFF);
    run_txn(0, 1, 4'hF, BASE + 4 * DEPTH, 32'hFFFF_FFFF);
    run_txn(0, 1, 4'hF, 32'h0010_0002, 32'hFFFF_FFFF);
    run_txn(0, 0, 4'hF, 32'h0000_0000, 32'h0);
    run_txn(0, 0, 4'hF, 32'h0010_0000, 32'h0);

    // back-to-back write then read of the same word
    a = 32'h0010_0040;
    d = $urandom;
    @(negedge clk);
    drive(0, 1, 1, 4'hF, a, d);
    #1;
    check("b2b_gnt_wr", 32'(if0.data_gnt_o), 32'd1);
    model_wr(0, a, 4'hF, d);
    @(negedge clk);
    drive(0, 1, 0, 4'hF, a, 32'h0);
    #1;
    check("b2b_gnt_rd", 32'(if0.data_gnt_o), 32'd1);
    check("b2b_rvalid_wr", 32'(if0.data_rvalid_o), 32'd1);
    check("b2b_rdata_wr", if0.data_rdata_o, 32'h0);
    @(negedge clk);
    drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
    #1;
    check("b2b_rvalid_rd", 32'(if0.data_rvalid_o), 32'd1);
    check("b2b_rdata_rd", if0.data_rdata_o, d);
    check("b2b_err_rd", 32'(if0.data_err_o), 32'd0);

    // stalled instance: continuous reads grant every fourth cycle
    run_txn(1, 1, 4'hF, 32'h0010_0010, 32'hC0FF_EE01);
    @(negedge clk);
    drive(1, 1, 0, 4'hF, 32'h0010_0010, 32'h0);
    for (int k = 0; k < 12; k++) begin
      #1;
      check("stall_gnt", 32'(if3.data_gnt_o), 32'((k % 4) == 3));
      check("stall_rvalid", 32'(if3.data_rvalid_o), 32'((k > 0) && ((k - 1) % 4) == 3));
      if ((k > 0) && ((k - 1) % 4) == 3) check("stall_rdata", if3.data_rdata_o, 32'hC0FF_EE01);
      @(negedge clk);
    end
    drive(1, 0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    drive(1, 1, 0, 4'hF, 32'h0010_0010, 32'h0);
    repeat (2) @(negedge clk);
    drive(1, 0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    drive(1, 1, 0, 4'hF, 32'h0010_0010, 32'h0);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("restall_gnt", 32'(if3.data_gnt_o), 32'(k == 3));
      check("restall_rvalid", 32'(if3.data_rvalid_o), 32'd0);
      @(negedge clk);
    end
    drive(1, 0, 0, 4'h0, 32'h0, 32'h0);

    // random traffic on the unstalled instance
    for (int i = 0; i < 16; i++) run_txn(0, 1, 4'hF, BASE + 32'(4 * (100 + i)), $urandom);
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 8)       a = BASE + 32'(4 * (100 + $urandom_range(0, 15)));
      else if (r == 8) a = BASE + 32'(4 * (100 + $urandom_range(0, 15))) + 32'($urandom_range(1, 3));
      else             a = ($urandom_range(0, 1) == 1) ? BASE - 32'd4 : BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 7));
      run_txn(0, 1'($urandom_range(0, 1)), 4'($urandom), a, $urandom);
    end

    // reset sampled at a read grant drops the response; writes under reset still land
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1, 0, 4'hF, 32'h0010_0004, 32'h0);
    #1;
    check("rstg_gnt", 32'(if0.data_gnt_o), 32'd1);
    @(negedge clk);
    drive(0, 1, 1, 4'hF, 32'h0010_0080, 32'h1357_9BDF);
    model_wr(0, 32'h0010_0080, 4'hF, 32'h1357_9BDF);
    #1;
    check("rstg_rvalid", 32'(if0.data_rvalid_o), 32'd0);
    check("rstg_rdata", if0.data_rdata_o, 32'h0);
    check("rstg_intg", 32'(if0.data_rdata_intg_o), 32'h0F);
    check("rstg_err", 32'(if0.data_err_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
    #1;
    check("rstw_rvalid", 32'(if0.data_rvalid_o), 32'd0);
    run_txn(0, 0, 4'hF, 32'h0010_0004, 32'h0);
    run_txn(0, 0, 4'hF, 32'h0010_0080, 32'h0);
    run_txn(1, 0, 4'hF, 32'h0010_0010, 32'h0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
